// File: rtl/morse_decoder_if.sv
// Bundles the tick-qualified Morse input and the decoded-letter outputs of morse_decoder.
interface morse_decoder_if;
    logic       tick;
    logic       morse_in;
    logic [2:0] letter;
    logic       valid;
    logic       err;
    logic       busy;

    modport master (
        output tick, morse_in,
        input  letter, valid, err, busy
    );

    modport slave (
        input  tick, morse_in,
        output letter, valid, err, busy
    );
endinterface

// File: rtl/morse_decoder.sv
// Recovers letters A-H from a tick-sampled Morse level.
// Define MORSE_DEC_STRICT_EN for exact run lengths (1 = dot, 3 = dash); otherwise any run >= 2 is a dash.
module morse_decoder #(
    parameter int GAP_TICKS = 3
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    morse_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [2:0] GAP_RUN = 3'(GAP_TICKS);

    state_t     state_q, state_d;
    logic [2:0] run_q, run_d;
    logic [3:0] shift_q, shift_d;
    logic [2:0] count_q, count_d;
    logic       bad_q, bad_d;
    logic [2:0] letter_q, letter_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic [2:0] run_inc;
    logic       sym;
    logic       run_ok;
    logic       hit;
    logic [2:0] code;

    assign run_inc = (run_q == 3'd7) ? 3'd7 : run_q + 3'd1;

    always_comb begin
`ifdef MORSE_DEC_STRICT_EN
        sym    = (run_q == 3'd3);
        run_ok = (run_q == 3'd1) || (run_q == 3'd3);
`else
        sym    = (run_q >= 3'd2);
        run_ok = 1'b1;
`endif
    end

    // Symbols enter at bit 0, so the first symbol sits in the highest used bit.
    always_comb begin
        hit  = 1'b1;
        code = 3'd0;
        case ({count_q, shift_q})
            {3'd2, 4'b0001}: code = 3'd0;
            {3'd4, 4'b1000}: code = 3'd1;
            {3'd4, 4'b1010}: code = 3'd2;
            {3'd3, 4'b0100}: code = 3'd3;
            {3'd1, 4'b0000}: code = 3'd4;
            {3'd4, 4'b0010}: code = 3'd5;
            {3'd3, 4'b0110}: code = 3'd6;
            {3'd4, 4'b0000}: code = 3'd7;
            default:         hit  = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        shift_d  = shift_q;
        count_d  = count_q;
        bad_d    = bad_q;
        letter_d = letter_q;
        err_d    = err_q;
        valid_d  = 1'b0;

        if (bus.tick) begin
            case (state_q)
                IDLE: begin
                    if (bus.morse_in) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                        shift_d = 4'd0;
                        count_d = 3'd0;
                        bad_d   = 1'b0;
                    end
                end
                MARK: begin
                    if (bus.morse_in) begin
                        run_d = run_inc;
                    end else begin
                        if (count_q == 3'd4) begin
                            bad_d = 1'b1;
                        end else begin
                            count_d = count_q + 3'd1;
                            if (run_ok) begin
                                shift_d = {shift_q[2:0], sym};
                            end else begin
                                bad_d = 1'b1;
                            end
                        end
                        state_d = SPACE;
                        run_d   = 3'd1;
                    end
                end
                SPACE: begin
                    if (bus.morse_in) begin
                        state_d = MARK;
                        run_d   = 3'd1;
                    end else begin
                        run_d = run_inc;
                        if (run_inc >= GAP_RUN) begin
                            state_d = IDLE;
                            valid_d = 1'b1;
                            if (hit && !bad_q) begin
                                letter_d = code;
                                err_d    = 1'b0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            run_q    <= 3'd0;
            shift_q  <= 4'd0;
            count_q  <= 3'd0;
            bad_q    <= 1'b0;
            letter_q <= 3'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            bad_q    <= bad_d;
            letter_q <= letter_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.letter = letter_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: letters are described as mark-run lengths and
// the expected letter/err is derived from dot/dash strings matched against the A-H table.
module tb_morse_decoder;

    localparam int GAP = 3;

    typedef struct packed {
        logic [2:0] letter;
        logic       err;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic resetn;

    morse_decoder_if bus ();

    morse_decoder #(.GAP_TICKS(GAP)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] model_letter;
    int         cur_runs[8];
    int         cur_n;
    string      table_pat[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: turn run lengths into a dot/dash string and look it up in the letter table.
    function automatic exp_t model();
        exp_t  e;
        string s;
        bit    bad;
        s   = "";
        bad = 1'b0;
        for (int i = 0; i < cur_n; i++) begin
            if (i >= 4) begin
                bad = 1'b1;
            end else begin
`ifdef MORSE_DEC_STRICT_EN
                if (cur_runs[i] == 1)      s = {s, "."};
                else if (cur_runs[i] == 3) s = {s, "-"};
                else                       bad = 1'b1;
`else
                if (cur_runs[i] >= 2) s = {s, "-"};
                else                  s = {s, "."};
`endif
            end
        end
        e.letter = model_letter;
        e.err    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!bad && s == table_pat[k]) begin
                e.letter = 3'(k);
                e.err    = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic sendTick(input logic v);
        repeat ($urandom_range(0, 2)) begin
            @(negedge CLOCK_50);
            bus.morse_in = 1'($urandom_range(0, 1));
        end
        @(negedge CLOCK_50);
        bus.tick     = 1'b1;
        bus.morse_in = v;
        @(negedge CLOCK_50);
        bus.tick     = 1'b0;
        bus.morse_in = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input string name);
        exp_t e;
        e = model();
        exp_q.push_back(e);
        model_letter = e.letter;
        repeat ($urandom_range(0, 2)) sendTick(1'b0);
        for (int i = 0; i < cur_n; i++) begin
            for (int k = 0; k < cur_runs[i]; k++) begin
                sendTick(1'b1);
                if (i == 0 && k == 0) checkOutput({name, " busy_start"}, 8'(bus.busy), 8'd1);
            end
            if (i < cur_n - 1) repeat ($urandom_range(1, GAP - 1)) sendTick(1'b0);
        end
        repeat (GAP - 1) sendTick(1'b0);
        sendTick(1'b0);
        checkOutput({name, " valid_pulse"}, 8'(bus.valid), 8'd1);
        checkOutput({name, " busy_end"}, 8'(bus.busy), 8'd0);
        @(negedge CLOCK_50);
        checkOutput({name, " valid_drop"}, 8'(bus.valid), 8'd0);
    endtask

    task automatic randomLetter();
        string p;
        if ($urandom_range(0, 1) == 1) begin
            p     = table_pat[$urandom_range(0, 7)];
            cur_n = p.len();
            for (int i = 0; i < cur_n; i++) begin
                if (p[i] == ".") begin
                    cur_runs[i] = 1;
                end else begin
`ifdef MORSE_DEC_STRICT_EN
                    cur_runs[i] = 3;
`else
                    cur_runs[i] = int'($urandom_range(2, 5));
`endif
                end
            end
        end else begin
            cur_n = int'($urandom_range(1, 5));
            for (int i = 0; i < cur_n; i++) cur_runs[i] = int'($urandom_range(1, 4));
        end
    endtask

    // Monitor: every valid strobe consumes one expectation.
    always @(negedge CLOCK_50) begin
        if (resetn === 1'b1 && bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid 1 expected no strobe at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("letter", 8'(bus.letter), 8'(mon_e.letter));
                checkOutput("err", 8'(bus.err), 8'(mon_e.err));
            end
        end
    end

    initial begin
        bus.tick     = 1'b0;
        bus.morse_in = 1'b0;
        resetn       = 1'b0;
        model_letter = 3'd0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset letter", 8'(bus.letter), 8'd0);
        checkOutput("reset valid", 8'(bus.valid), 8'd0);
        checkOutput("reset err", 8'(bus.err), 8'd0);
        checkOutput("reset busy", 8'(bus.busy), 8'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50);

        cur_n = 2; cur_runs[0] = 1; cur_runs[1] = 3;
        applyStimulus("send_A");

        cur_n = 4; cur_runs[0] = 3; cur_runs[1] = 1; cur_runs[2] = 1; cur_runs[3] = 1;
        applyStimulus("send_B");
        cur_n = 1; cur_runs[0] = 1;
        applyStimulus("send_E");

        cur_n = 1; cur_runs[0] = 2;
        applyStimulus("run_of_2");

        cur_n = 4; cur_runs[0] = 2; cur_runs[1] = 1; cur_runs[2] = 2; cur_runs[3] = 1;
        applyStimulus("short_dash_C");

        cur_n = 5;
        for (int i = 0; i < 5; i++) cur_runs[i] = 1;
        applyStimulus("five_dots");

        bus.tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            bus.morse_in = ~bus.morse_in;
            checkOutput("no_tick busy", 8'(bus.busy), 8'd0);
            checkOutput("no_tick valid", 8'(bus.valid), 8'd0);
        end

        sendTick(1'b1); sendTick(1'b1); sendTick(1'b1);
        sendTick(1'b0); sendTick(1'b1);
        resetn = 1'b0;
        #1;
        checkOutput("midreset letter", 8'(bus.letter), 8'd0);
        checkOutput("midreset valid", 8'(bus.valid), 8'd0);
        checkOutput("midreset err", 8'(bus.err), 8'd0);
        checkOutput("midreset busy", 8'(bus.busy), 8'd0);
        @(negedge CLOCK_50);
        resetn       = 1'b1;
        model_letter = 3'd0;
        cur_n = 2; cur_runs[0] = 1; cur_runs[1] = 3;
        applyStimulus("after_reset_A");

        for (int n = 0; n < 60; n++) begin
            randomLetter();
            applyStimulus("random");
        end

        repeat (10) @(negedge CLOCK_50);
        checkOutput("drain pending", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side companion to the Morse encoder (the design whose top is `part3`): it samples the serial Morse level (the encoder's LEDR[0] output) on each half-second enable tick and recovers which of the letters A–H was sent. It drives a 3-bit letter code, a one-cycle valid strobe and an error flag, for loop-back checking on the board or display on HEX/LEDR. It shares the encoder's clock and its half-second enable, so both advance on identical ticks.

## Interface
- `GAP_TICKS`, default 3: consecutive low ticks that end a letter. Legal range is 2..7.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `resetn`  in  1  asynchronous, active-low reset, driven from KEY[0].
- `tick`  in  1  half-second enable, one CLOCK_50 cycle wide; all decoding advances only on cycles with `tick`=1.
- `morse_in`  in  1  serial Morse level (1 = mark), sampled only when `tick`=1.
- `letter`  out  3  decoded letter, A=0 … H=7; held until the next valid decode.
- `valid`  out  1  one-cycle strobe: `letter`/`err` were just updated.
- `err`  out  1  last letter was malformed; held until the next strobe.
- `busy`  out  1  a letter is in progress (state is MARK or SPACE).

## Operation
- Symbol timing: dot = 1 high tick, dash = 3 high ticks, intra-letter gap = 1 low tick, letter end = `GAP_TICKS` low ticks.
- Letter codes (dot=0, dash=1, first symbol first):
  - A .- ; B -... ; C -.-. ; D -..
  - E . ; F ..-. ; G --. ; H ....
- Internal state:
  - 3-bit `run` counter, saturating at 7.
  - 4-bit symbol shift register.
  - 3-bit symbol count, 0..4.
  - sticky `bad` bit.
- IDLE:
  - tick with `morse_in`=1 → MARK, `run`=1, symbol count=0, `bad`=0.
  - tick with `morse_in`=0 → stay in IDLE.
- MARK:
  - tick with 1 → `run`++ (saturating).
  - tick with 0 → classify `run` as a symbol, then go to SPACE with `run`=1.
  - Classification: if symbol count=4 already, set `bad` (fifth symbol) and do not shift; otherwise shift the symbol in and increment the count.
- SPACE:
  - tick with 1 → MARK, `run`=1.
  - tick with 0 → `run`++. When `run` reaches `GAP_TICKS`, decode and go to IDLE.
- Decode: look up (count, pattern). If it matches A–H and `bad`=0, load `letter` and set `err`=0. Otherwise leave `letter` unchanged and set `err`=1. Pulse `valid` in either case.
- Decode condition: `valid` goes high exactly once per letter.
- Any pattern outside the table (for example `--` or `---`) is an error.

## Timing
- Reset (async, any state) gives IDLE, `letter`=0, `valid`=0, `err`=0, `busy`=0, all counters 0. Recovery is synchronous to `CLOCK_50`.
- Reset in the middle of a letter discards the partial letter; no `valid` is issued.
- Cycles with `tick`=0 change no state. `morse_in` transitions between ticks are ignored.
- Latency: `letter`, `err` and `valid` update on the same `CLOCK_50` edge that samples the gap-completing tick. `valid` is high for exactly that next cycle and is 0 on the following cycle.
- `busy` is registered. It is 1 from the edge that enters MARK until the edge that returns to IDLE.
- A letter that starts immediately after the letter-end gap is accepted. The next tick in IDLE with `morse_in`=1 begins it, with no lost tick.

## Configuration
- `MORSE_DEC_STRICT_EN` defined (strict):
  - mark run 1 → dot; run 3 → dash.
  - runs 2 or ≥4 set `bad`; the symbol is not shifted, but the count still increments.
- `MORSE_DEC_STRICT_EN` not defined (lenient):
  - run 1 → dot; run ≥2 → dash.
  - No run-length errors; fifth-symbol and unknown-pattern errors still apply.

## Test plan
- **Send A** (1,0,1,1,1 then 3 lows, `tick` every 3 clocks):
  - `valid` pulses once, 1 cycle after the 3rd low tick.
  - `letter`=0, `err`=0; `busy` returns to 0 on the same edge.
- **Send B then E back-to-back** (B pattern, 3 lows, then 1, 3 lows):
  - Two `valid` pulses.
  - `letter`=1, then `letter`=4; `err`=0 both times.
- **Strict build, mark run of 2** (1,1,0,0,0):
  - `valid` with `err`=1 and `letter` unchanged.
  - Lenient build, same stimulus: `letter`=0? No, a lone dash is not in the table, so `err`=1.
  - Lenient build, `-.-.` sent with 2-tick dashes: `letter`=2, `err`=0.
- **Five dots** (1,0 ×5, then 3 lows): `valid`, `err`=1, `letter` held at its previous value.
- **`morse_in` toggled while `tick`=0 for 20 clocks:** no state change; `busy`=0, `valid`=0 throughout.
- **Reset mid-letter** (`resetn` low after `-.`, released, then A sent):
  - All outputs are 0 during reset; no `valid` for the partial letter.
  - A then decodes to `letter`=0, `err`=0.
